// File: rtl/rs_alu.sv
// Reservation station for ALU-class instructions. Holds issued instructions until
// both operands are valid (snooping CDBA for wakeups) and dispatches the
// lowest-index ready slot to the ALU, one per cycle.
module rs_alu #(
    parameter int unsigned RS_SIZE = 16,
    parameter int unsigned ROB_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clr,
    input  logic             IS_sgn,
    input  logic [5:0]       IS_opcode,
    input  logic             IS_rdy1,
    input  logic             IS_rdy2,
    input  logic [31:0]      IS_val1,
    input  logic [31:0]      IS_val2,
    input  logic [ROB_W-1:0] IS_ord1,
    input  logic [ROB_W-1:0] IS_ord2,
    input  logic [31:0]      IS_imm,
    input  logic [31:0]      IS_pc,
    input  logic [ROB_W-1:0] ROB_name,
    output logic             RS_full,
    input  logic             CDBA_sgn,
    input  logic [31:0]      CDBA_result,
    input  logic [ROB_W-1:0] CDBA_ROB_name,
    output logic             ALU_sgn,
    output logic [5:0]       ALU_opcode,
    output logic [31:0]      ALU_val1,
    output logic [31:0]      ALU_val2,
    output logic [31:0]      ALU_imm,
    output logic [31:0]      ALU_pc,
    output logic [ROB_W-1:0] ALU_ROB_name
);
    localparam int unsigned IdxW = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] busy_q, busy_d;
    logic [RS_SIZE-1:0] rdy1_q, rdy1_d;
    logic [RS_SIZE-1:0] rdy2_q, rdy2_d;
    logic [5:0]         opcode_q [RS_SIZE];
    logic [5:0]         opcode_d [RS_SIZE];
    logic [31:0]        val1_q   [RS_SIZE];
    logic [31:0]        val1_d   [RS_SIZE];
    logic [31:0]        val2_q   [RS_SIZE];
    logic [31:0]        val2_d   [RS_SIZE];
    logic [ROB_W-1:0]   ord1_q   [RS_SIZE];
    logic [ROB_W-1:0]   ord1_d   [RS_SIZE];
    logic [ROB_W-1:0]   ord2_q   [RS_SIZE];
    logic [ROB_W-1:0]   ord2_d   [RS_SIZE];
    logic [31:0]        imm_q    [RS_SIZE];
    logic [31:0]        imm_d    [RS_SIZE];
    logic [31:0]        pc_q     [RS_SIZE];
    logic [31:0]        pc_d     [RS_SIZE];
    logic [ROB_W-1:0]   rob_q    [RS_SIZE];
    logic [ROB_W-1:0]   rob_d    [RS_SIZE];

    logic             alu_sgn_q, alu_sgn_d;
    logic [5:0]       alu_opcode_q, alu_opcode_d;
    logic [31:0]      alu_val1_q, alu_val1_d;
    logic [31:0]      alu_val2_q, alu_val2_d;
    logic [31:0]      alu_imm_q, alu_imm_d;
    logic [31:0]      alu_pc_q, alu_pc_d;
    logic [ROB_W-1:0] alu_rob_q, alu_rob_d;

    logic            free_found, sel_found;
    logic [IdxW-1:0] free_idx, sel_idx;
    logic            byp1, byp2;

    assign RS_full = &busy_q;

    // Priority encoders: lowest free slot for issue, lowest ready slot for dispatch.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = int'(RS_SIZE) - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IdxW'(i);
            end
            if (busy_q[i] && rdy1_q[i] && rdy2_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IdxW'(i);
            end
        end
    end

    // Operand captured straight off CDBA when its producer broadcasts during issue.
    assign byp1 = !IS_rdy1 && CDBA_sgn && (IS_ord1 == CDBA_ROB_name);
    assign byp2 = !IS_rdy2 && CDBA_sgn && (IS_ord2 == CDBA_ROB_name);

    // Next state: flush, wakeup, dispatch and issue; issue never targets the dispatched slot.
    always_comb begin
        busy_d       = busy_q;
        rdy1_d       = rdy1_q;
        rdy2_d       = rdy2_q;
        opcode_d     = opcode_q;
        val1_d       = val1_q;
        val2_d       = val2_q;
        ord1_d       = ord1_q;
        ord2_d       = ord2_q;
        imm_d        = imm_q;
        pc_d         = pc_q;
        rob_d        = rob_q;
        alu_sgn_d    = 1'b0;
        alu_opcode_d = alu_opcode_q;
        alu_val1_d   = alu_val1_q;
        alu_val2_d   = alu_val2_q;
        alu_imm_d    = alu_imm_q;
        alu_pc_d     = alu_pc_q;
        alu_rob_d    = alu_rob_q;
        if (rdy) begin
            if (clr) begin
                busy_d = '0;
            end else begin
                if (CDBA_sgn) begin
                    for (int i = 0; i < int'(RS_SIZE); i++) begin
                        if (busy_q[i] && !rdy1_q[i] && (ord1_q[i] == CDBA_ROB_name)) begin
                            rdy1_d[i] = 1'b1;
                            val1_d[i] = CDBA_result;
                        end
                        if (busy_q[i] && !rdy2_q[i] && (ord2_q[i] == CDBA_ROB_name)) begin
                            rdy2_d[i] = 1'b1;
                            val2_d[i] = CDBA_result;
                        end
                    end
                end
                if (sel_found) begin
                    alu_sgn_d       = 1'b1;
                    alu_opcode_d    = opcode_q[sel_idx];
                    alu_val1_d      = val1_q[sel_idx];
                    alu_val2_d      = val2_q[sel_idx];
                    alu_imm_d       = imm_q[sel_idx];
                    alu_pc_d        = pc_q[sel_idx];
                    alu_rob_d       = rob_q[sel_idx];
                    busy_d[sel_idx] = 1'b0;
                end
                if (IS_sgn && free_found) begin
                    busy_d[free_idx]   = 1'b1;
                    opcode_d[free_idx] = IS_opcode;
                    rdy1_d[free_idx]   = IS_rdy1 || byp1;
                    rdy2_d[free_idx]   = IS_rdy2 || byp2;
                    val1_d[free_idx]   = IS_rdy1 ? IS_val1 : CDBA_result;
                    val2_d[free_idx]   = IS_rdy2 ? IS_val2 : CDBA_result;
                    ord1_d[free_idx]   = IS_ord1;
                    ord2_d[free_idx]   = IS_ord2;
                    imm_d[free_idx]    = IS_imm;
                    pc_d[free_idx]     = IS_pc;
                    rob_d[free_idx]    = ROB_name;
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q       <= '0;
            rdy1_q       <= '0;
            rdy2_q       <= '0;
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                opcode_q[i] <= '0;
                val1_q[i]   <= '0;
                val2_q[i]   <= '0;
                ord1_q[i]   <= '0;
                ord2_q[i]   <= '0;
                imm_q[i]    <= '0;
                pc_q[i]     <= '0;
                rob_q[i]    <= '0;
            end
            alu_sgn_q    <= 1'b0;
            alu_opcode_q <= '0;
            alu_val1_q   <= '0;
            alu_val2_q   <= '0;
            alu_imm_q    <= '0;
            alu_pc_q     <= '0;
            alu_rob_q    <= '0;
        end else begin
            busy_q       <= busy_d;
            rdy1_q       <= rdy1_d;
            rdy2_q       <= rdy2_d;
            opcode_q     <= opcode_d;
            val1_q       <= val1_d;
            val2_q       <= val2_d;
            ord1_q       <= ord1_d;
            ord2_q       <= ord2_d;
            imm_q        <= imm_d;
            pc_q         <= pc_d;
            rob_q        <= rob_d;
            alu_sgn_q    <= alu_sgn_d;
            alu_opcode_q <= alu_opcode_d;
            alu_val1_q   <= alu_val1_d;
            alu_val2_q   <= alu_val2_d;
            alu_imm_q    <= alu_imm_d;
            alu_pc_q     <= alu_pc_d;
            alu_rob_q    <= alu_rob_d;
        end
    end

    assign ALU_sgn      = alu_sgn_q;
    assign ALU_opcode   = alu_opcode_q;
    assign ALU_val1     = alu_val1_q;
    assign ALU_val2     = alu_val2_q;
    assign ALU_imm      = alu_imm_q;
    assign ALU_pc       = alu_pc_q;
    assign ALU_ROB_name = alu_rob_q;

endmodule

// File: tb/tb_rs_alu.sv
// Self-checking bench for rs_alu: directed scenarios followed by random traffic,
// all compared against a slot-table reference model.
module tb_rs_alu;
    logic        clk = 1'b0;
    logic        rst, rdy, clr;
    logic        is_sgn, is_rdy1, is_rdy2;
    logic [5:0]  is_opcode;
    logic [31:0] is_val1, is_val2, is_imm, is_pc;
    logic [3:0]  is_ord1, is_ord2, rob_name;
    logic        rs_full;
    logic        cdb_sgn;
    logic [31:0] cdb_res;
    logic [3:0]  cdb_tag;
    logic        alu_sgn;
    logic [5:0]  alu_opcode;
    logic [31:0] alu_val1, alu_val2, alu_imm, alu_pc;
    logic [3:0]  alu_rob;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rs_alu #(.RS_SIZE(16), .ROB_W(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .IS_sgn(is_sgn), .IS_opcode(is_opcode), .IS_rdy1(is_rdy1), .IS_rdy2(is_rdy2),
        .IS_val1(is_val1), .IS_val2(is_val2), .IS_ord1(is_ord1), .IS_ord2(is_ord2),
        .IS_imm(is_imm), .IS_pc(is_pc), .ROB_name(rob_name), .RS_full(rs_full),
        .CDBA_sgn(cdb_sgn), .CDBA_result(cdb_res), .CDBA_ROB_name(cdb_tag),
        .ALU_sgn(alu_sgn), .ALU_opcode(alu_opcode), .ALU_val1(alu_val1),
        .ALU_val2(alu_val2), .ALU_imm(alu_imm), .ALU_pc(alu_pc), .ALU_ROB_name(alu_rob)
    );

    // Reference model: one record per station slot plus the expected ALU register.
    typedef struct {
        bit        busy;
        bit [5:0]  op;
        bit        r1, r2;
        bit [31:0] v1, v2, imm, pc;
        bit [3:0]  o1, o2, rob;
    } ent_t;

    ent_t      m [16];
    bit        e_sgn;
    bit [5:0]  e_op;
    bit [31:0] e_v1, e_v2, e_imm, e_pc;
    bit [3:0]  e_rob;

    function automatic bit m_full();
        for (int i = 0; i < 16; i++) if (!m[i].busy) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
        e_sgn = 0; e_op = 0; e_v1 = 0; e_v2 = 0; e_imm = 0; e_pc = 0; e_rob = 0;
    endtask

    // Apply one clock edge's worth of behaviour to the model using the driven inputs.
    task automatic model_edge();
        int sel = -1;
        int fr  = -1;
        if (!rdy) begin
            e_sgn = 0;
            return;
        end
        if (clr) begin
            for (int i = 0; i < 16; i++) m[i].busy = 1'b0;
            e_sgn = 0;
            return;
        end
        for (int i = 0; i < 16; i++) begin
            if (sel < 0 && m[i].busy && m[i].r1 && m[i].r2) sel = i;
            if (fr < 0 && !m[i].busy) fr = i;
        end
        if (cdb_sgn) begin
            for (int i = 0; i < 16; i++) begin
                if (m[i].busy && !m[i].r1 && m[i].o1 == cdb_tag) begin
                    m[i].r1 = 1; m[i].v1 = cdb_res;
                end
                if (m[i].busy && !m[i].r2 && m[i].o2 == cdb_tag) begin
                    m[i].r2 = 1; m[i].v2 = cdb_res;
                end
            end
        end
        e_sgn = (sel >= 0);
        if (sel >= 0) begin
            e_op = m[sel].op; e_v1 = m[sel].v1; e_v2 = m[sel].v2;
            e_imm = m[sel].imm; e_pc = m[sel].pc; e_rob = m[sel].rob;
            m[sel].busy = 0;
        end
        if (is_sgn && fr >= 0) begin
            m[fr].busy = 1;
            m[fr].op   = is_opcode;
            m[fr].o1   = is_ord1;
            m[fr].o2   = is_ord2;
            m[fr].imm  = is_imm;
            m[fr].pc   = is_pc;
            m[fr].rob  = rob_name;
            if (is_rdy1) begin m[fr].r1 = 1; m[fr].v1 = is_val1; end
            else if (cdb_sgn && is_ord1 == cdb_tag) begin m[fr].r1 = 1; m[fr].v1 = cdb_res; end
            else m[fr].r1 = 0;
            if (is_rdy2) begin m[fr].r2 = 1; m[fr].v2 = is_val2; end
            else if (cdb_sgn && is_ord2 == cdb_tag) begin m[fr].r2 = 1; m[fr].v2 = cdb_res; end
            else m[fr].r2 = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".sgn"},  32'(alu_sgn),    32'(e_sgn));
        chk({tag, ".full"}, 32'(rs_full),    32'(m_full()));
        chk({tag, ".op"},   32'(alu_opcode), 32'(e_op));
        chk({tag, ".v1"},   alu_val1,        e_v1);
        chk({tag, ".v2"},   alu_val2,        e_v2);
        chk({tag, ".imm"},  alu_imm,         e_imm);
        chk({tag, ".pc"},   alu_pc,          e_pc);
        chk({tag, ".rob"},  32'(alu_rob),    32'(e_rob));
    endtask

    // One clock: model the edge, wait for it, compare 1 time unit later, drop pulses.
    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
        is_sgn = 0; cdb_sgn = 0; clr = 0;
    endtask

    task automatic issue(input logic [5:0] op, input logic r1, input logic [31:0] v1,
                         input logic [3:0] o1, input logic r2, input logic [31:0] v2,
                         input logic [3:0] o2, input logic [3:0] rob);
        is_sgn = 1; is_opcode = op; is_rdy1 = r1; is_val1 = v1; is_ord1 = o1;
        is_rdy2 = r2; is_val2 = v2; is_ord2 = o2; rob_name = rob;
        is_imm = 32'h100 + 32'(rob); is_pc = 32'h8000_0000 + 32'(op);
    endtask

    task automatic broadcast(input logic [3:0] tag, input logic [31:0] res);
        cdb_sgn = 1; cdb_tag = tag; cdb_res = res;
    endtask

    initial begin
        rst = 1; rdy = 1; clr = 0; is_sgn = 0; cdb_sgn = 0;
        is_opcode = 0; is_rdy1 = 0; is_rdy2 = 0; is_val1 = 0; is_val2 = 0;
        is_ord1 = 0; is_ord2 = 0; is_imm = 0; is_pc = 0; rob_name = 0;
        cdb_res = 0; cdb_tag = 0;
        model_reset();
        #12;
        check_all("reset");
        rst = 0;

        // Both operands ready: dispatch one edge after issue.
        issue(6'd1, 1, 32'd5, 4'd0, 1, 32'd7, 4'd0, 4'd3);
        tick("t1.issue");
        chk("t1.no_early", 32'(alu_sgn), 32'd0);
        tick("t1.disp");
        chk("t1.sgn", 32'(alu_sgn), 32'd1);
        chk("t1.v1", alu_val1, 32'd5);
        chk("t1.v2", alu_val2, 32'd7);
        chk("t1.rob", 32'(alu_rob), 32'd3);
        tick("t1.after");
        chk("t1.sgn_low", 32'(alu_sgn), 32'd0);
        chk("t1.not_full", 32'(rs_full), 32'd0);

        // Wakeup via CDBA two cycles after issue.
        issue(6'd2, 0, 32'd0, 4'd6, 1, 32'd1, 4'd0, 4'd4);
        tick("t2.issue");
        tick("t2.wait");
        chk("t2.wait_sgn", 32'(alu_sgn), 32'd0);
        broadcast(4'd6, 32'h1234);
        tick("t2.wake");
        chk("t2.not_same_cycle", 32'(alu_sgn), 32'd0);
        tick("t2.disp");
        chk("t2.sgn", 32'(alu_sgn), 32'd1);
        chk("t2.v1", alu_val1, 32'h1234);

        // Issue-time bypass from CDBA.
        issue(6'd3, 1, 32'd11, 4'd0, 0, 32'd0, 4'd2, 4'd5);
        broadcast(4'd2, 32'd9);
        tick("t3.issue");
        tick("t3.disp");
        chk("t3.sgn", 32'(alu_sgn), 32'd1);
        chk("t3.v2", alu_val2, 32'd9);

        // Fill all 16 slots with waiting operands, then overflow.
        for (int i = 0; i < 16; i++) begin
            issue(6'd4, 0, 32'd0, 4'(i), 1, 32'd2, 4'd0, 4'(i));
            tick("t4.fill");
        end
        chk("t4.full", 32'(rs_full), 32'd1);
        issue(6'd5, 1, 32'd1, 4'd0, 1, 32'd1, 4'd0, 4'd15);
        tick("t4.overflow");
        chk("t4.still_full", 32'(rs_full), 32'd1);
        broadcast(4'd0, 32'hABCD);
        tick("t4.wake0");
        tick("t4.disp0");
        chk("t4.sgn", 32'(alu_sgn), 32'd1);
        chk("t4.rob0", 32'(alu_rob), 32'd0);
        chk("t4.freed", 32'(rs_full), 32'd0);
        clr = 1;
        tick("t4.clr");

        // Three ready entries flushed by clr alongside a new issue.
        for (int i = 0; i < 3; i++) begin
            issue(6'd6, 0, 32'd0, 4'd9, 1, 32'd3, 4'd0, 4'(i + 7));
            tick("t5.fill");
        end
        broadcast(4'd9, 32'd77);
        tick("t5.wake");
        clr = 1;
        issue(6'd7, 1, 32'd1, 4'd0, 1, 32'd1, 4'd0, 4'd12);
        tick("t5.clr");
        chk("t5.sgn", 32'(alu_sgn), 32'd0);
        chk("t5.empty", 32'(rs_full), 32'd0);
        for (int i = 0; i < 3; i++) tick("t5.quiet");

        // Asynchronous reset mid-cycle with entries pending.
        issue(6'd8, 1, 32'd21, 4'd0, 1, 32'd22, 4'd0, 4'd1);
        tick("t6.issue_a");
        issue(6'd9, 0, 32'd0, 4'd13, 1, 32'd23, 4'd0, 4'd2);
        tick("t6.issue_b");
        #3;
        rst = 1;
        #1;
        model_reset();
        check_all("t6.async_rst");
        #1;
        rst = 0;

        // rdy low freezes everything for three cycles.
        issue(6'd10, 1, 32'd31, 4'd0, 1, 32'd32, 4'd0, 4'd6);
        tick("t7.issue");
        rdy = 0;
        for (int i = 0; i < 3; i++) tick("t7.stall");
        rdy = 1;
        tick("t7.resume");
        chk("t7.sgn", 32'(alu_sgn), 32'd1);
        chk("t7.v1", alu_val1, 32'd31);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rdy = ($urandom_range(0, 7) != 0);
            if (rdy) begin
                if (!m_full() && $urandom_range(0, 1) == 1)
                    issue(6'($urandom), 1'($urandom), $urandom, 4'($urandom),
                          1'($urandom), $urandom, 4'($urandom), 4'($urandom));
                if ($urandom_range(0, 1) == 1) broadcast(4'($urandom), $urandom);
                clr = ($urandom_range(0, 39) == 0);
            end
            tick("rand");
        end
        rdy = 1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
